// File: rtl/ft_pkg.sv
// Shared types and helpers for the fault-tolerant TMR datapath.
package ft_pkg;

  localparam int unsigned N_REPLICA = 3;

  typedef logic [1:0] replica_idx_t;

  // Default vote mask, wide enough for the deepest supported pipeline.
  localparam logic [3:0] FT_VOTE_ALL = 4'hF;

  // Bitwise 2-of-3 majority of one bit position.
  function automatic logic ft_majority(input logic x, input logic y, input logic z);
    return (x & y) | (y & z) | (x & z);
  endfunction

endpackage

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 voter with per-replica mismatch flags and a no-majority-word indication.
module tmr_voter
  import ft_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic [N_REPLICA-1:0][WIDTH-1:0] words_i,
  output logic [WIDTH-1:0]                voted_o,
  output logic [N_REPLICA-1:0]            mismatch_o,
  output logic                            fatal_o
);

  always_comb begin
    voted_o = '0;
    for (int b = 0; b < int'(WIDTH); b++) begin
      voted_o[b] = ft_majority(words_i[0][b], words_i[1][b], words_i[2][b]);
    end
  end

  always_comb begin
    mismatch_o = '0;
    for (int i = 0; i < int'(N_REPLICA); i++) begin
      mismatch_o[i] = (words_i[i] != voted_o);
    end
  end

  // No pair agrees on the whole word; the bitwise majority is still driven.
  assign fatal_o = (words_i[0] != words_i[1]) && (words_i[1] != words_i[2]) &&
                   (words_i[0] != words_i[2]);

endmodule

// File: rtl/adder_ft_pipe.sv
// TMR pipelined adder with per-stage optional scrubbing and a voted, gated output.
// Define FT_ERR_CNT_EN to add the per-replica saturating error counters.
module adder_ft_pipe
  import ft_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       STAGES    = 2,
  parameter logic [STAGES-1:0] VOTE_MASK = FT_VOTE_ALL[STAGES-1:0],
  parameter int unsigned       CNT_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [N_REPLICA-1:0][WIDTH-1:0] a_i,
  input  logic [N_REPLICA-1:0][WIDTH-1:0] b_i,
  input  logic [N_REPLICA-1:0]            cin_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [WIDTH-1:0]                sum_o,
  output logic                            cout_o,
  output logic                            err_o,
  output logic [N_REPLICA-1:0]            err_replica_o,
  output logic                            fatal_o
`ifdef FT_ERR_CNT_EN
  ,
  input  logic                            clear_cnt_i,
  output logic [N_REPLICA-1:0][CNT_W-1:0] err_cnt_o
`endif
);

  localparam int unsigned DW = WIDTH + 1;

  typedef logic [N_REPLICA-1:0][DW-1:0] rep_t;

  rep_t              sum_in;
  rep_t              stage_d [STAGES];
  rep_t [STAGES-1:0] stage_q;
  logic [STAGES-1:0] vld_q;
  logic              advance;

  always_comb begin
    for (int i = 0; i < int'(N_REPLICA); i++) begin
      sum_in[i] = DW'(a_i[i]) + DW'(b_i[i]) + DW'(cin_i[i]);
    end
  end

  for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
    rep_t stage_in;

    if (s == 0) begin : g_first
      assign stage_in = sum_in;
    end else begin : g_rest
      assign stage_in = stage_q[s-1];
    end

    if (VOTE_MASK[s]) begin : g_scrub
      logic [DW-1:0]        voted;
      logic [N_REPLICA-1:0] unused_mismatch;
      logic                 unused_fatal;

      tmr_voter #(
        .WIDTH (DW)
      ) u_voter (
        .words_i    (stage_in),
        .voted_o    (voted),
        .mismatch_o (unused_mismatch),
        .fatal_o    (unused_fatal)
      );

      assign stage_d[s] = {N_REPLICA{voted}};
    end else begin : g_pass
      assign stage_d[s] = stage_in;
    end
  end

  assign valid_o = vld_q[STAGES-1];
  assign advance = !valid_o || ready_i;
  assign ready_o = advance;

  // Whole pipeline moves in lockstep; a stall freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      stage_q <= '0;
    end else if (advance) begin
      vld_q[0] <= valid_i;
      for (int s = 1; s < int'(STAGES); s++) begin
        vld_q[s] <= vld_q[s-1];
      end
      for (int s = 0; s < int'(STAGES); s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  logic [DW-1:0]        out_voted;
  logic [N_REPLICA-1:0] out_mismatch;
  logic                 out_fatal;

  tmr_voter #(
    .WIDTH (DW)
  ) u_out_voter (
    .words_i    (stage_q[STAGES-1]),
    .voted_o    (out_voted),
    .mismatch_o (out_mismatch),
    .fatal_o    (out_fatal)
  );

  assign sum_o         = valid_o ? out_voted[WIDTH-1:0] : '0;
  assign cout_o        = valid_o & out_voted[WIDTH];
  assign err_replica_o = valid_o ? out_mismatch : '0;
  assign err_o         = |err_replica_o;
  assign fatal_o       = valid_o & out_fatal;

`ifdef FT_ERR_CNT_EN
  logic [N_REPLICA-1:0][CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_cnt_i) begin
      cnt_d = '0;
    end else if (valid_o && ready_i) begin
      for (int i = 0; i < int'(N_REPLICA); i++) begin
        if (err_replica_o[i] && (cnt_q[i] != '1)) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt_o = cnt_q;
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_adder_ft_pipe.sv
// Directed self-checking bench: one non-scrubbing and one stage-0-scrubbing instance.
module tb_adder_ft_pipe;

  logic             clk;
  logic             rst_n;
  logic             valid_i;
  logic             ready_i;
  logic [2:0][7:0]  a;
  logic [2:0][7:0]  b;
  logic [2:0]       cin;

  logic             ready0, valid0, cout0, err0, fatal0;
  logic [7:0]       sum0;
  logic [2:0]       rep0;
  logic             ready1, valid1, cout1, err1, fatal1;
  logic [7:0]       sum1;
  logic [2:0]       rep1;

`ifdef FT_ERR_CNT_EN
  logic             clear_cnt;
  logic [2:0][1:0]  cnt0;
  logic [2:0][1:0]  cnt1;
`endif

  int checks = 0;
  int errors = 0;

  adder_ft_pipe #(
    .WIDTH     (8),
    .STAGES    (2),
    .VOTE_MASK (2'b00),
    .CNT_W     (2)
  ) dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_i       (valid_i),
    .ready_o       (ready0),
    .a_i           (a),
    .b_i           (b),
    .cin_i         (cin),
    .valid_o       (valid0),
    .ready_i       (ready_i),
    .sum_o         (sum0),
    .cout_o        (cout0),
    .err_o         (err0),
    .err_replica_o (rep0),
    .fatal_o       (fatal0)
`ifdef FT_ERR_CNT_EN
    ,
    .clear_cnt_i   (clear_cnt),
    .err_cnt_o     (cnt0)
`endif
  );

  adder_ft_pipe #(
    .WIDTH     (8),
    .STAGES    (2),
    .VOTE_MASK (2'b01),
    .CNT_W     (2)
  ) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_i       (valid_i),
    .ready_o       (ready1),
    .a_i           (a),
    .b_i           (b),
    .cin_i         (cin),
    .valid_o       (valid1),
    .ready_i       (ready_i),
    .sum_o         (sum1),
    .cout_o        (cout1),
    .err_o         (err1),
    .err_replica_o (rep1),
    .fatal_o       (fatal1)
`ifdef FT_ERR_CNT_EN
    ,
    .clear_cnt_i   (clear_cnt),
    .err_cnt_o     (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one vector for one cycle, then wait until it reaches the output.
  task automatic send_one(input logic [23:0] av, input logic [23:0] bv, input logic [2:0] cv);
    a       = av;
    b       = bv;
    cin     = cv;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    check("latency_not_early", 32'(valid0), 'h0);
    step();
  endtask

  initial begin
    int sent;
    int got;

    rst_n   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    a       = '0;
    b       = '0;
    cin     = '0;
`ifdef FT_ERR_CNT_EN
    clear_cnt = 1'b0;
`endif
    #1;
    check("rst_valid", 32'(valid0), 'h0);
    check("rst_ready", 32'(ready0), 'h1);
    check("rst_sum", 32'(sum0), 'h0);
    check("rst_err", 32'({err0, rep0, fatal0, cout0}), 'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Replica 0 differs: visible without scrubbing, hidden by stage-0 scrub.
    send_one({8'h25, 8'h25, 8'h21}, {3{8'h45}}, 3'b000);
    check("t1_valid", 32'(valid0), 'h1);
    check("t1_sum", 32'(sum0), 'h6A);
    check("t1_cout", 32'(cout0), 'h0);
    check("t1_err", 32'(err0), 'h1);
    check("t1_rep", 32'(rep0), 'h1);
    check("t1_fatal", 32'(fatal0), 'h0);
    check("t1s_sum", 32'(sum1), 'h6A);
    check("t1s_err", 32'(err1), 'h0);
    check("t1s_rep", 32'(rep1), 'h0);
    step();
    check("t1_drained", 32'(valid0), 'h0);
    check("t1_gated_sum", 32'(sum0), 'h0);

    // Carry out of the top bit.
    send_one({3{8'hFF}}, {3{8'h01}}, 3'b000);
    check("t2_sum", 32'(sum0), 'h00);
    check("t2_cout", 32'(cout0), 'h1);
    check("t2_err", 32'(err0), 'h0);
    step();

    // Carry-in per replica.
    send_one({3{8'h10}}, {3{8'h20}}, 3'b111);
    check("t2c_sum", 32'(sum0), 'h31);
    step();

    // No two replicas agree.
    send_one({8'h01, 8'h02, 8'h04}, {3{8'h00}}, 3'b000);
    check("t3_fatal", 32'(fatal0), 'h1);
    check("t3_rep", 32'(rep0), 'h7);
    check("t3_sum", 32'(sum0), 'h00);
    check("t3s_fatal", 32'(fatal1), 'h0);
    check("t3s_rep", 32'(rep1), 'h0);
    step();

    // Back-to-back stream with a 3-cycle downstream stall.
    sent = 0;
    got  = 0;
    b    = {3{8'h10}};
    cin  = 3'b000;
    for (int cyc = 0; cyc < 20; cyc++) begin
      ready_i = !(cyc >= 2 && cyc <= 4);
      if (sent < 6) begin
        valid_i = 1'b1;
        a       = {3{8'(sent + 1)}};
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc <= 4) check("stall_ready", 32'(ready0), 'h0);
      if (valid0 && ready_i) begin
        check("stream_data", 32'(sum0), 32'('h10 + got + 1));
        got++;
      end
      if (valid_i && ready0) sent++;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    check("stream_count", 32'(got), 'd6);

`ifdef FT_ERR_CNT_EN
    clear_cnt = 1'b1;
    step();
    clear_cnt = 1'b0;
    check("cnt_cleared", 32'(cnt0), 'h0);
    // Five handshakes with replica 1 corrupted saturate its 2-bit counter.
    a       = {8'h10, 8'h11, 8'h10};
    b       = {3{8'h01}};
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("cnt_r1_sat", 32'(cnt0[1]), 'd3);
    check("cnt_r0", 32'(cnt0[0]), 'd0);
    check("cnt_r2", 32'(cnt0[2]), 'd0);
    // Clear wins over a simultaneous error handshake.
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    check("cnt_pre_clear_err", 32'(rep0), 'h2);
    clear_cnt = 1'b1;
    step();
    clear_cnt = 1'b0;
    check("cnt_clear_wins", 32'(cnt0[1]), 'd0);
    send_one({8'h10, 8'h11, 8'h10}, {3{8'h01}}, 3'b000);
    step();
    check("cnt_one_after", 32'(cnt0[1]), 'd1);
`endif

    // Reset with both stages holding valid data.
    a       = {3{8'h05}};
    b       = {3{8'h06}};
    cin     = 3'b000;
    valid_i = 1'b1;
    step();
    step();
    valid_i = 1'b0;
    check("mid_valid_before", 32'(valid0), 'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid0), 'h0);
    check("mid_rst_ready", 32'(ready0), 'h1);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_no_ghost", 32'(valid0), 'h0);
    send_one({3{8'h07}}, {3{8'h08}}, 3'b000);
    check("post_rst_valid", 32'(valid0), 'h1);
    check("post_rst_sum", 32'(sum0), 'h0F);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
